dcm_pll_ctrl: RTL and testbench

//  Reset/lock sequencer for the dcm_pll clock generator in the memory controller.
//  - Drives the PLL reset and waits for lock, with a timeout and bounded retries.
//  - Releases the downstream controller reset only after lock has been continuously stable.
//  - Detects loss of lock and re-initialises the PLL.
//  - Runs on a free-running reference clock, never on a PLL output.

---
 rtl/dcm_pll_ctrl_pkg.sv | 18 +
 rtl/dcm_pll_lock_sync.sv | 21 ++
 rtl/dcm_pll_ctrl.sv | 138 +++++++++++++
 tb/tb_dcm_pll_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dcm_pll_ctrl_pkg.sv
// Shared types for the dcm_pll reset/lock sequencer.
// State values match the encodings used by status/debug readback.
package dcm_pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    // The PLL is held in reset while initialising and while parked in FAULT.
    function automatic logic holds_pll_rst(state_e s);
        return (s == ST_PLL_RST) || (s == ST_FAULT);
    endfunction

endpackage

// File: rtl/dcm_pll_lock_sync.sv
// Two-flop synchroniser for the asynchronous PLL lock indication.
module dcm_pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/dcm_pll_ctrl.sv
// Reset/lock sequencer for the dcm_pll clock generator: PLL reset, lock wait with
// bounded retries, stable-lock qualification and loss-of-lock recovery.
module dcm_pll_ctrl
    import dcm_pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned MAX_RETRY    = 7,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned RETRY_W      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               lock_lost
);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    logic               lock_s;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lost_d;
    logic               pll_rst_q, sys_rst_q, ready_q, fault_q, lost_q;

    dcm_pll_lock_sync u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (lock_s)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        lost_d  = 1'b0;
        if (restart) begin
            state_d = ST_PLL_RST;
            timer_d = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_PLL_RST: begin
                    if (timer_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d = ST_PLL_RST;
                            retry_d = retry_q + 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_STABLE: begin
                    // A lock drop here only requalifies; it does not count as a retry.
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_PLL_RST;
                        timer_d = '0;
                        retry_d = '0;
                        lost_d  = 1'b1;
                    end
                end
                ST_FAULT: ;
                default: begin
                    state_d = ST_PLL_RST;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PLL_RST;
            timer_q   <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            pll_rst_q <= holds_pll_rst(state_d);
            sys_rst_q <= (state_d != ST_RUN);
            ready_q   <= (state_d == ST_RUN);
            fault_q   <= (state_d == ST_FAULT);
            lost_q    <= lost_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign lock_lost = lost_q;

endmodule

// File: tb/tb_dcm_pll_ctrl.sv
// Scoreboard bench for dcm_pll_ctrl: directed scenarios plus randomized lock/restart traffic.
module tb_dcm_pll_ctrl;

    localparam int unsigned P_RST     = 4;
    localparam int unsigned P_TIMEOUT = 20;
    localparam int unsigned P_STABLE  = 8;
    localparam int unsigned P_MAXR    = 2;

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic       fault;
        logic [2:0] retry;
        logic       lost;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, sys_rst, ready, fault, lock_lost;
    logic [2:0] retry_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    obs_t        sb_q[$];

    always #5 clk = ~clk;

    dcm_pll_ctrl #(
        .RST_CYCLES   (P_RST),
        .LOCK_TIMEOUT (P_TIMEOUT),
        .LOCK_STABLE  (P_STABLE),
        .MAX_RETRY    (P_MAXR),
        .CNT_W        (16),
        .RETRY_W      (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .lock_lost  (lock_lost)
    );

    // Reference model: named phases with countdowns of remaining cycles,
    // and the synchroniser seen as a two-sample delay line.
    string       m_phase = "RST";
    int          m_left  = P_RST;
    int          m_retry = 0;
    bit          m_lost  = 1'b0;
    bit          m_hist[$] = '{1'b0, 1'b0};

    task automatic model_edge(input bit r, input bit rs, input bit pl);
        bit ls;
        ls = m_hist[0];
        void'(m_hist.pop_front());
        m_hist.push_back(pl);
        m_lost = 1'b0;
        if (r) begin
            m_phase = "RST"; m_left = P_RST; m_retry = 0;
            m_hist = '{1'b0, 1'b0};
        end else if (rs) begin
            m_phase = "RST"; m_left = P_RST; m_retry = 0;
        end else if (m_phase == "RST") begin
            m_left--;
            if (m_left == 0) begin m_phase = "WAIT"; m_left = P_TIMEOUT; end
        end else if (m_phase == "WAIT") begin
            if (ls) begin
                m_phase = "STAB"; m_left = P_STABLE;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_retry == P_MAXR) m_phase = "FAULT";
                    else begin m_retry++; m_phase = "RST"; m_left = P_RST; end
                end
            end
        end else if (m_phase == "STAB") begin
            if (!ls) begin
                m_phase = "WAIT"; m_left = P_TIMEOUT;
            end else begin
                m_left--;
                if (m_left == 0) m_phase = "RUN";
            end
        end else if (m_phase == "RUN") begin
            if (!ls) begin
                m_phase = "RST"; m_left = P_RST; m_retry = 0; m_lost = 1'b1;
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.pll_rst = (m_phase == "RST") || (m_phase == "FAULT");
        o.sys_rst = (m_phase != "RUN");
        o.ready   = (m_phase == "RUN");
        o.fault   = (m_phase == "FAULT");
        o.retry   = 3'(m_retry);
        o.lost    = m_lost;
        return o;
    endfunction

    // Drive one cycle of inputs and queue the response expected after the next edge.
    task automatic step(input bit r, input bit rs, input bit pl);
        @(negedge clk);
        rst = r; restart = rs; pll_locked = pl;
        model_edge(r, rs, pl);
        sb_q.push_back(model_obs());
    endtask

    task automatic steps(input int n, input bit pl);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, pl);
    endtask

    task automatic check(input string name, input int act, input int exp);
        @(posedge clk);
        #2;
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        obs_t act, exp;
        #1;
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            act = '{pll_rst, sys_rst, ready, fault, retry_cnt, lock_lost};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL outputs t=%0t: got rst=%b sys=%b rdy=%b flt=%b retry=%0d lost=%b expected rst=%b sys=%b rdy=%b flt=%b retry=%0d lost=%b",
                         $time, act.pll_rst, act.sys_rst, act.ready, act.fault, act.retry, act.lost,
                         exp.pll_rst, exp.sys_rst, exp.ready, exp.fault, exp.retry, exp.lost);
            end
        end
    end

    initial begin
        // Reset, then PLL reset window with lock low.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("reset_pll_rst", int'(pll_rst), 1);
        steps(3, 1'b0);
        steps(5, 1'b0);
        check("wait_pll_rst", int'(pll_rst), 0);
        // Lock five cycles into WAIT_LOCK, hold until released.
        steps(20, 1'b1);
        check("run_ready", int'(ready), 1);
        // Loss of lock in RUN, then re-lock.
        steps(3, 1'b0);
        steps(30, 1'b1);
        check("relock_ready", int'(ready), 1);
        // Short lock drop landing mid-STABLE.
        steps(2, 1'b0);
        steps(8, 1'b1);
        steps(1, 1'b0);
        steps(30, 1'b1);
        check("glitch_retry", int'(retry_cnt), 0);
        // No lock at all: retries exhaust into FAULT, which is held.
        steps(180, 1'b0);
        check("fault_set", int'(fault), 1);
        check("fault_retry", int'(retry_cnt), 2);
        // Restart in FAULT, then restart coinciding with the first WAIT_LOCK timeout.
        step(1'b0, 1'b1, 1'b0);
        steps(23, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("restart_retry", int'(retry_cnt), 0);
        check("restart_fault", int'(fault), 0);
        // Randomized segments of lock level with occasional restart and reset.
        for (int seg = 0; seg < 80; seg++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
            for (int i = 0; i < len; i++)
                step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) == 0), lvl);
        end
        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
